// File: rtl/ball_pixel_engine.sv
// Per-pixel ball hit-test stage.
// Software writes ball position, radius and enable into a shadow set.
// A commit write arms a swap. The next falling edge of VGA_VS copies the
// shadow set into the active set, so a frame never mixes old and new balls.
// Every cycle, the current DrawX/DrawY is tested against all active balls
// through a two-stage pipeline. The lowest-index hit wins.
module ball_pixel_engine #(
  parameter int NUM_BALLS = 4,
  parameter int COORD_W   = 10,
  parameter int RAD_W     = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               wr_en,
  input  logic [4:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               VGA_VS,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               is_ball,
  output logic [1:0]         ballID,
  output logic               commit_pending,
  output logic [15:0]        frame_count
);

  localparam int DIFF_W = COORD_W + 1;
  localparam int SUM_W  = 2 * COORD_W + 1;
  localparam int R2_W   = 2 * RAD_W;

  // |a - b| taken from an 11-bit signed difference; the magnitude always fits COORD_W bits
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic [DIFF_W-1:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[DIFF_W-1]) begin
      d = ~d + DIFF_W'(1);
    end else begin
      d = d;
    end
    return d[COORD_W-1:0];
  endfunction

  // Register file: shadow (software view) and active (what is drawn)
  logic [COORD_W-1:0] sh_x_q  [NUM_BALLS];
  logic [COORD_W-1:0] sh_y_q  [NUM_BALLS];
  logic [RAD_W-1:0]   sh_r_q  [NUM_BALLS];
  logic               sh_en_q [NUM_BALLS];
  logic [COORD_W-1:0] act_x_q [NUM_BALLS];
  logic [COORD_W-1:0] act_y_q [NUM_BALLS];
  logic [RAD_W-1:0]   act_r_q [NUM_BALLS];
  logic               act_en_q[NUM_BALLS];

  // Frame-swap control
  logic        vs_q;
  logic        commit_pending_q, commit_pending_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        vs_fall_s, swap_s, commit_wr_s, ball_wr_s;
  logic [1:0]  wr_ball_s, wr_field_s;
  logic        unused_wr_s;

  // Pipeline stage 1 and stage 2
  logic [COORD_W-1:0] dx_q[NUM_BALLS], dx_d[NUM_BALLS];
  logic [COORD_W-1:0] dy_q[NUM_BALLS], dy_d[NUM_BALLS];
  logic [R2_W-1:0]    r2_q[NUM_BALLS], r2_d[NUM_BALLS];
  logic               en_q[NUM_BALLS], en_d[NUM_BALLS];
  logic [SUM_W-1:0]   sum_s[NUM_BALLS];
  logic [NUM_BALLS-1:0] hit_s;
  logic               is_ball_q, is_ball_d;
  logic [1:0]         ball_id_q, ball_id_d;

  assign wr_ball_s   = wr_addr[3:2];
  assign wr_field_s  = wr_addr[1:0];
  assign ball_wr_s   = wr_en & ~wr_addr[4];
  assign commit_wr_s = wr_en & (wr_addr == 5'd16);
  assign unused_wr_s = ^wr_data[31:COORD_W];
  assign vs_fall_s   = vs_q & ~VGA_VS;
  // A commit written on the vs_fall cycle is not yet pending, so it waits a frame
  assign swap_s      = vs_fall_s & commit_pending_q;

  // Software writes into the shadow set; upper data bits are dropped
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        sh_x_q[i]  <= '0;
        sh_y_q[i]  <= '0;
        sh_r_q[i]  <= '0;
        sh_en_q[i] <= 1'b0;
      end
    end else if (ball_wr_s) begin
      case (wr_field_s)
        2'd0:    sh_x_q[wr_ball_s]  <= wr_data[COORD_W-1:0];
        2'd1:    sh_y_q[wr_ball_s]  <= wr_data[COORD_W-1:0];
        2'd2:    sh_r_q[wr_ball_s]  <= wr_data[RAD_W-1:0];
        2'd3:    sh_en_q[wr_ball_s] <= wr_data[0];
        default: sh_en_q[wr_ball_s] <= sh_en_q[wr_ball_s];
      endcase
    end
  end

  // Shadow-to-active copy on a committed frame edge; the copy sees pre-write shadow values
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        act_x_q[i]  <= '0;
        act_y_q[i]  <= '0;
        act_r_q[i]  <= '0;
        act_en_q[i] <= 1'b0;
      end
    end else if (swap_s) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        act_x_q[i]  <= sh_x_q[i];
        act_y_q[i]  <= sh_y_q[i];
        act_r_q[i]  <= sh_r_q[i];
        act_en_q[i] <= sh_en_q[i];
      end
    end
  end

  // Next-state for the commit flag and the swap counter
  always_comb begin
    commit_pending_d = commit_pending_q;
    frame_count_d    = frame_count_q;
    if (commit_wr_s) begin
      commit_pending_d = 1'b1;
    end else if (swap_s) begin
      commit_pending_d = 1'b0;
    end else begin
      commit_pending_d = commit_pending_q;
    end
    if (swap_s) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Frame-swap control registers; vs_q idles high like the sync it follows
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_q             <= 1'b1;
      commit_pending_q <= 1'b0;
      frame_count_q    <= 16'd0;
    end else begin
      vs_q             <= VGA_VS;
      commit_pending_q <= commit_pending_d;
      frame_count_q    <= frame_count_d;
    end
  end

  // Stage 1 next-state: per-ball distance magnitudes and squared radius
  always_comb begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      dx_d[i] = abs_diff(DrawX, act_x_q[i]);
      dy_d[i] = abs_diff(DrawY, act_y_q[i]);
      r2_d[i] = R2_W'(act_r_q[i]) * R2_W'(act_r_q[i]);
      en_d[i] = act_en_q[i];
    end
  end

  // Stage 1 registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        dx_q[i] <= '0;
        dy_q[i] <= '0;
        r2_q[i] <= '0;
        en_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        dx_q[i] <= dx_d[i];
        dy_q[i] <= dy_d[i];
        r2_q[i] <= r2_d[i];
        en_q[i] <= en_d[i];
      end
    end
  end

  // Stage 2 next-state: circle test per ball, then lowest-index priority pick
  always_comb begin
    hit_s     = '0;
    is_ball_d = 1'b0;
    ball_id_d = 2'd0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      sum_s[i] = SUM_W'(dx_q[i]) * SUM_W'(dx_q[i]) + SUM_W'(dy_q[i]) * SUM_W'(dy_q[i]);
      hit_s[i] = en_q[i] & (sum_s[i] <= SUM_W'(r2_q[i]));
    end
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        ball_id_d = 2'(i);
      end else begin
        ball_id_d = ball_id_d;
      end
    end
    is_ball_d = |hit_s;
  end

  // Stage 2 registers drive the outputs directly
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_ball_q <= 1'b0;
      ball_id_q <= 2'd0;
    end else begin
      is_ball_q <= is_ball_d;
      ball_id_q <= ball_id_d;
    end
  end

  assign is_ball        = is_ball_q;
  assign ballID         = ball_id_q;
  assign commit_pending = commit_pending_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_ball_pixel_engine.sv
// Self-checking bench for ball_pixel_engine.
// A frame-level model predicts every output each cycle, and directed
// literal checks pin the key scenarios.
module tb_ball_pixel_engine;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        VGA_VS;
  logic [9:0]  DrawX, DrawY;
  logic        is_ball;
  logic [1:0]  ballID;
  logic        commit_pending;
  logic [15:0] frame_count;

  ball_pixel_engine dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .VGA_VS(VGA_VS), .DrawX(DrawX), .DrawY(DrawY), .is_ball(is_ball), .ballID(ballID),
    .commit_pending(commit_pending), .frame_count(frame_count)
  );

  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: software-visible balls, displayed balls, swap bookkeeping
  int m_sx[4], m_sy[4], m_sr[4], m_sen[4];
  int m_ax[4], m_ay[4], m_ar[4], m_aen[4];
  int m_pending, m_frame, m_vs_prev;
  int pred_now_hit, pred_now_id, pred_last_hit, pred_last_id;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 4; b++) begin
      m_sx[b] = 0; m_sy[b] = 0; m_sr[b] = 0; m_sen[b] = 0;
      m_ax[b] = 0; m_ay[b] = 0; m_ar[b] = 0; m_aen[b] = 0;
    end
    m_pending = 0; m_frame = 0; m_vs_prev = 1;
    pred_now_hit = 0; pred_now_id = 0; pred_last_hit = 0; pred_last_id = 0;
  endfunction

  // Circle test against displayed balls; first enabled ball in index order wins
  function automatic void predict(input int px, input int py, output int hit, output int id);
    hit = 0; id = 0;
    for (int b = 0; b < 4; b++) begin
      if (hit == 0 && m_aen[b] != 0 &&
          (px - m_ax[b]) * (px - m_ax[b]) + (py - m_ay[b]) * (py - m_ay[b]) <= m_ar[b] * m_ar[b]) begin
        hit = 1; id = b;
      end
    end
  endfunction

  // Model: one step per clock edge from the inputs present at that edge
  initial begin
    int vs_fall, swap, a;
    model_reset();
    forever begin
      @(posedge Clk);
      cyc++;
      if (Reset) begin
        model_reset();
      end else begin
        pred_last_hit = pred_now_hit;
        pred_last_id  = pred_now_id;
        predict(int'(DrawX), int'(DrawY), pred_now_hit, pred_now_id);
        vs_fall = (m_vs_prev == 1 && VGA_VS == 1'b0) ? 1 : 0;
        swap    = (vs_fall == 1 && m_pending == 1) ? 1 : 0;
        if (swap == 1) begin
          for (int b = 0; b < 4; b++) begin
            m_ax[b] = m_sx[b]; m_ay[b] = m_sy[b]; m_ar[b] = m_sr[b]; m_aen[b] = m_sen[b];
          end
          m_frame = (m_frame + 1) % 65536;
        end
        a = int'(wr_addr);
        if (wr_en && a < 16) begin
          case (a % 4)
            0: m_sx[a / 4]  = int'(wr_data) & 1023;
            1: m_sy[a / 4]  = int'(wr_data) & 1023;
            2: m_sr[a / 4]  = int'(wr_data) & 63;
            default: m_sen[a / 4] = int'(wr_data) & 1;
          endcase
        end
        if (wr_en && a == 16) m_pending = 1;
        else if (swap == 1) m_pending = 0;
        m_vs_prev = int'(VGA_VS);
      end
    end
  end

  // Compare process: every falling edge outside reset
  initial begin
    forever begin
      @(negedge Clk);
      if (!Reset && cyc >= 2) begin
        chk("model_is_ball", int'(is_ball), pred_last_hit);
        chk("model_ballID", int'(ballID), pred_last_id);
        chk("model_commit_pending", int'(commit_pending), m_pending);
        chk("model_frame_count", int'(frame_count), m_frame);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = 5'(addr); wr_data = data;
    tick();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
  endtask

  // Upper data bits are set to show they are ignored
  task automatic set_ball(input int b, input int x, input int y, input int r, input int en);
    wr(4 * b + 0, 32'hFFFF_FC00 | 32'(x));
    wr(4 * b + 1, 32'hFFFF_FC00 | 32'(y));
    wr(4 * b + 2, 32'hFFFF_FFC0 | 32'(r));
    wr(4 * b + 3, 32'hFFFF_FFFE | 32'(en));
  endtask

  task automatic vs_pulse();
    VGA_VS = 1'b0; tick();
    VGA_VS = 1'b1; tick();
  endtask

  task automatic probe(input int x, input int y, input int eh, input int eid, input string nm);
    DrawX = 10'(x); DrawY = 10'(y);
    tick(); tick();
    chk({nm, "_is_ball"}, int'(is_ball), eh);
    chk({nm, "_ballID"}, int'(ballID), eid);
  endtask

  initial begin
    Reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    VGA_VS = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    chk("reset_frame_count", int'(frame_count), 0);
    chk("reset_commit_pending", int'(commit_pending), 0);
    chk("reset_is_ball", int'(is_ball), 0);

    // Sweep with no balls enabled, then an uncommitted frame edge
    for (int i = 0; i < 20; i++) begin
      DrawX = 10'(i * 37); DrawY = 10'(i * 23);
      tick();
    end
    vs_pulse();
    chk("idle_frame_count", int'(frame_count), 0);

    // Ball1 at (100,50) r=5, ball3 at (5,5) r=0
    set_ball(1, 100, 50, 5, 1);
    set_ball(3, 5, 5, 0, 1);
    wr(16, 32'd0);
    chk("commit_pending_set", int'(commit_pending), 1);
    vs_pulse();
    chk("swap1_frame_count", int'(frame_count), 1);
    chk("swap1_commit_pending", int'(commit_pending), 0);
    probe(104, 54, 0, 0, "edge_miss");
    DrawX = 10'd103; DrawY = 10'd54;
    tick();
    chk("latency_1cyc_is_ball", int'(is_ball), 0);
    tick();
    chk("latency_2cyc_is_ball", int'(is_ball), 1);
    chk("latency_2cyc_ballID", int'(ballID), 1);
    probe(97, 46, 1, 1, "neg_diff");
    probe(5, 5, 1, 3, "r0_centre");
    probe(6, 5, 0, 0, "r0_right");
    probe(5, 4, 0, 0, "r0_above");
    for (int i = 0; i < 12; i++) begin
      DrawX = 10'(i); DrawY = 10'(11 - i);
      tick();
    end

    // Overlapping balls 0 and 2: lowest index wins
    set_ball(0, 200, 200, 10, 1);
    set_ball(2, 205, 200, 10, 1);
    wr(16, 32'd0);
    vs_pulse();
    chk("swap2_frame_count", int'(frame_count), 2);
    probe(200, 200, 1, 0, "overlap");
    probe(212, 200, 1, 2, "ball2_only");

    // Shadow write without commit never reaches the screen
    wr(0, 32'd300);
    vs_pulse();
    chk("nocommit_pending", int'(commit_pending), 0);
    chk("nocommit_frame_count", int'(frame_count), 2);
    probe(200, 200, 1, 0, "nocommit_hold");

    // Disable ball0 and commit; visible only after the next frame edge
    wr(3, 32'd0);
    wr(16, 32'd0);
    probe(200, 200, 1, 0, "before_swap");
    vs_pulse();
    chk("swap3_frame_count", int'(frame_count), 3);
    probe(200, 200, 1, 2, "after_swap");

    // Commit written on the vs_fall cycle waits one more frame
    VGA_VS = 1'b0; wr_en = 1'b1; wr_addr = 5'd16; wr_data = 32'd0;
    tick();
    wr_en = 1'b0; wr_addr = 5'd0; VGA_VS = 1'b1;
    tick();
    chk("coincident_pending", int'(commit_pending), 1);
    chk("coincident_frame_count", int'(frame_count), 3);
    vs_pulse();
    chk("deferred_pending", int'(commit_pending), 0);
    chk("deferred_frame_count", int'(frame_count), 4);

    // Asynchronous reset mid-frame while a ball is hit
    wr(16, 32'd0);
    DrawX = 10'd200; DrawY = 10'd200;
    tick(); tick();
    chk("pre_reset_is_ball", int'(is_ball), 1);
    #1 Reset = 1'b1;
    #1;
    chk("async_reset_is_ball", int'(is_ball), 0);
    chk("async_reset_pending", int'(commit_pending), 0);
    chk("async_reset_frame_count", int'(frame_count), 0);
    tick();
    Reset = 1'b0;
    tick();
    probe(200, 200, 0, 0, "post_reset_b2");
    probe(103, 54, 0, 0, "post_reset_b1");
    vs_pulse();
    chk("post_reset_frame_count", int'(frame_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
